delay_line_ctrl: RTL
====================

// Module: delay_line_ctrl
// PURPOSE
//  Sequences one simple-dual-port single-clock BRAM as a circular audio delay line.
//  Each accepted input sample is written at the write pointer; the sample from DELAY positions earlier is read back.
//  Sits between the sample source (e.g. I2S RX or a filter) and the echo/mix stage.
//  The RAM itself is external; this block owns all of its address, write and read timing.
// PARAMETERS
//  ADDR_WIDTH  8   RAM address width; the buffer holds 2**ADDR_WIDTH samples
//  DATA_WIDTH  12  sample width in bits
// PORTS
//  clk          in   1           single system clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  delay        in   ADDR_WIDTH  delay in samples, 0..2**ADDR_WIDTH-1; sampled when a sample is accepted
//  in_valid     in   1           input sample strobe
//  in_data      in   DATA_WIDTH  input sample
//  in_ready     out  1           high when a sample can be accepted (state IDLE and rst low)
//  out_valid    out  1           one-cycle strobe: out_data holds the delayed sample
//  out_data     out  DATA_WIDTH  delayed sample
//  overrun      out  1           sticky: in_valid was seen while in_ready was low
//  overrun_clr  in   1           clears overrun; a new overrun in the same cycle wins
//  ram_rd_addr  out  ADDR_WIDTH  RAM read address
//  ram_wr_addr  out  ADDR_WIDTH  RAM write address
//  ram_wr_en    out  1           RAM write enable
//  ram_wr_data  out  DATA_WIDTH  RAM write data
//  ram_rd_data  in   DATA_WIDTH  RAM read data; registered, valid one cycle after the address
// BEHAVIOUR
//  Reset:
//   - All outputs 0. in_ready=0 while rst is high.
//   - wr_ptr=0, fill=0, state=IDLE.
//   - RAM contents are not cleared. The fill counter masks stale data.
//  States: IDLE -> ACCESS -> RESP -> IDLE. Each accepted sample takes exactly 3 cycles.
//  Cycle T, IDLE with in_valid=1:
//   - latch in_data to data_q and delay to dly_q; go to ACCESS.
//  Cycle T+1, ACCESS:
//   - ram_rd_addr = wr_ptr - dly_q (mod 2**ADDR_WIDTH).
//   - ram_wr_addr = wr_ptr, ram_wr_data = data_q, ram_wr_en = 1 for this cycle only.
//   - wr_ptr increments and wraps; fill increments and saturates at 2**ADDR_WIDTH-1.
//   - Go to RESP.
//  Cycle T+2, RESP:
//   - out_data is registered from:
//     - data_q, if dly_q == 0 (bypass; avoids same-address read/write);
//     - 0, if fill (before the increment) < dly_q (buffer not yet primed);
//     - ram_rd_data otherwise.
//   - Go to IDLE.
//  Cycle T+3:
//   - out_valid = 1 for one cycle; in_ready = 1.
//   - Latency from in_valid to out_valid is 3 cycles.
//  With dly_q >= 1, read and write addresses always differ, so read-during-write ordering does not matter.
//  in_valid while in_ready = 0: the sample is dropped and overrun is set.
//  A change on delay takes effect on the next accepted sample only. No re-priming:
//   - output is 0 while fill < new delay;
//   - otherwise the output is the sample from new-delay positions earlier.
//  rst in ACCESS or RESP aborts the operation: no out_valid, pointer and fill return to 0.
//   A write already issued in ACCESS stays in the RAM but is masked by fill.
//  ram_rd_addr, ram_wr_addr and ram_wr_data hold their last values outside ACCESS; ram_wr_en = 0.
// TESTING
//  1. Reset, delay=4, samples 1..10 sent 4 cycles apart
//     -> out_data 0,0,0,0,1,2,3,4,5,6; each out_valid 3 cycles after its in_valid.
//  2. delay=0, samples 0x123 and 0xABC
//     -> out_data 0x123 then 0xABC; ram_wr_en still pulses once per sample.
//  3. ADDR_WIDTH=3, delay=7, samples 1..20
//     -> outputs 0 x7, then 1..13; ram_wr_addr wraps 7 -> 0.
//  4. in_valid held high for 9 cycles starting in IDLE
//     -> exactly 3 samples accepted; overrun=1; pulsing overrun_clr -> overrun=0.
//  5. rst pulsed during ACCESS, then delay=2, samples 5,6,7
//     -> no out_valid from the aborted sample; outputs 0,0,5.
//  6. delay=2 for samples 1..10, then delay=5 for samples 11,12
//     -> outputs for 11 and 12 are 6 and 7.

Source files
------------

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : delay_line_ctrl
//  Purpose  : Address/write/read sequencer for an external simple-dual-port,
//             single-clock BRAM that is used as a circular audio delay line.
//             Each accepted sample is written at the write pointer. The sample
//             written DELAY positions earlier is read back and presented on
//             out_data.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             delay               - delay in samples, latched on accept
//             in_valid/in_data    - input sample strobe and data
//             in_ready            - high when a sample can be accepted
//             out_valid/out_data  - one-cycle strobe and the delayed sample
//             overrun/overrun_clr - sticky dropped-sample flag and its clear
//             ram_*               - RAM address, write and read-data signals
//  Revision : 1.0 - initial release
// ============================================================================
module delay_line_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_fill_max = '1;
  localparam logic [ADDR_WIDTH-1:0] c_one      = ADDR_WIDTH'(1);

  state_t                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   fill_q,      fill_d;
  logic [ADDR_WIDTH-1:0]   dly_q,       dly_d;
  logic [DATA_WIDTH-1:0]   data_q,      data_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q,   rd_addr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q,   wr_addr_d;
  logic                    wr_en_q,     wr_en_d;
  logic                    unprimed_q,  unprimed_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic                    overrun_q,   overrun_d;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign overrun     = overrun_q;
  assign ram_rd_addr = rd_addr_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_en   = wr_en_q;
  // data_q only changes on accept, so it is valid throughout ACCESS and
  // holds its value afterwards.
  assign ram_wr_data = data_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    data_d      = data_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = 1'b0;
    unprimed_d  = unprimed_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    // A fresh overrun takes priority over a clear in the same cycle.
    if (in_valid && !in_ready) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // RAM controls are registered here so they are presented to the
          // RAM for exactly the ACCESS cycle.
          data_d    = in_data;
          dly_d     = delay;
          rd_addr_d = wr_ptr_q - delay;
          wr_addr_d = wr_ptr_q;
          wr_en_d   = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Fill is compared before its increment: the location being read
        // holds a real sample only if at least dly_q samples precede it.
        unprimed_d = (fill_q < dly_q);
        wr_ptr_d   = wr_ptr_q + c_one;
        fill_d     = (fill_q == c_fill_max) ? fill_q : fill_q + c_one;
        state_d    = RESP;
      end
      RESP: begin
        if (dly_q == '0) begin
          out_data_d = data_q;
        end else if (unprimed_q) begin
          out_data_d = '0;
        end else begin
          out_data_d = ram_rd_data;
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      dly_q       <= '0;
      data_q      <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      unprimed_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      data_q      <= data_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      unprimed_q  <= unprimed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule
`default_nettype wire
